clk_period_meter: RTL
=====================

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter W, default 27: width of the period counter and result.
REQ-002 Parameter TIMEOUT, default 50_000_000: number of clk cycles with no edge before timeout (0.4 s at 125 MHz).
REQ-003 clk  input  1  system clock, 125 MHz; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  measurement enable; synchronous.
REQ-006 clk_in  input  1  slow square wave to measure (e.g. 5 Hz divider output), asynchronous to clk.
REQ-007 period  output  W  last measured period, in clk cycles.
REQ-008 period_valid  output  1  one-cycle pulse when period updates.
REQ-009 locked  output  1  high while consecutive edges arrive within TIMEOUT.
REQ-010 timeout  output  1  sticky flag; no edge seen within TIMEOUT.

Function
REQ-011 clk_in SHALL pass through a 2-flop synchronizer plus one history flop; edge = sync2 & ~hist.
REQ-012 FSM states SHALL be IDLE, ARM, MEAS.
REQ-013 IDLE: cycle counter held at 0; en=1 -> ARM next cycle.
REQ-014 ARM: counter increments each cycle; first edge -> MEAS with counter reset to 0; no period_valid.
REQ-015 MEAS: counter increments; on edge, period <= counter+1, counter <= 0, period_valid=1 on the next cycle, locked=1.
REQ-016 Input period of N clk cycles SHALL yield period=N exactly once steady.
REQ-017 Latency: period_valid SHALL rise 4 clk cycles after the clk edge that first samples clk_in high.
REQ-018 In ARM or MEAS, counter reaching TIMEOUT-1 with no edge SHALL set timeout=1, clear locked, reset the counter and enter ARM.
REQ-019 timeout SHALL clear on the next detected edge.
REQ-020 Edge and timeout in the same cycle: the edge takes priority and no timeout is raised.
REQ-021 en=0 in any state SHALL force IDLE next cycle and clear locked and timeout; period holds its value.
REQ-022 Counter SHALL saturate at 2^W-1 and never wrap; TIMEOUT must be below 2^W.
REQ-023 period_valid SHALL never be high for two consecutive cycles.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, counter 0, period 0, period_valid 0, locked 0, timeout 0, and all synchronizer flops to 0.
REQ-025 rst asserted mid-measurement SHALL discard the partial count; no period_valid SHALL follow the release of reset.

Configuration
REQ-026 Macro PERIOD_AVG_EN.
REQ-027 Defined: period SHALL be the sum of the last 4 measured periods, using a W+2 bit accumulator, shifted right by 2 (truncated).
REQ-028 Defined: period_valid SHALL be suppressed until 4 periods have been collected since entering MEAS, then pulse on every edge.
REQ-029 Defined: any timeout, en=0 or rst SHALL clear the 4-entry history and the fill count.
REQ-030 Undefined: no averaging logic; REQ-015 applies directly.

Verification (W=16, TIMEOUT=100)
REQ-031 Square wave on clk_in with period 20 clk, en=1 -> first period_valid on the 2nd rising edge, period=20, locked=1, then a valid pulse every 20 cycles.
REQ-032 clk_in stops high for 150 cycles -> timeout=1 and locked=0 exactly 100 cycles after the last edge; restart -> timeout clears on the first edge; period_valid returns on the second edge.
REQ-033 en dropped mid-period -> IDLE; period holds 20; locked=0; re-enable -> ARM, with no valid pulse until two edges are seen.
REQ-034 rst pulsed for 3 cycles mid-count -> all outputs 0 during reset; the next valid period after resume is 20 and is not a partial count.
REQ-035 PERIOD_AVG_EN defined, periods 20, 22, 18, 24 -> no valid pulse for the first three; the fourth gives period=21.
REQ-036 Edge arriving exactly at counter=TIMEOUT-1 -> period=100, timeout stays 0.

Source files
------------

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period of a slow asynchronous square wave in clk cycles.
// Define PERIOD_AVG_EN to report the truncated average of the last four periods instead.
module clk_period_meter #(
    parameter int W       = 27,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clk_in,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         locked,
    output logic         timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_t;

    localparam logic [W-1:0] TIMEOUT_LAST = W'(TIMEOUT - 1);
    localparam logic [W-1:0] COUNT_MAX    = '1;

    logic         sync1_q;
    logic         sync2_q;
    logic         syncHist_q;
    logic         edge_q;
    state_t       state_q;
    logic [W-1:0] count_q;
    logic [W-1:0] countInc;
    logic [W-1:0] rawPeriod_q;
    logic         measDone_q;
    logic         locked_q;
    logic         timeout_q;
    logic [W-1:0] period_q;
    logic         valid_q;

    assign countInc = (count_q == COUNT_MAX) ? count_q : count_q + W'(1);

    // Two-flop synchronizer, history flop and a registered rising-edge strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            syncHist_q <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            sync1_q    <= clk_in;
            sync2_q    <= sync1_q;
            syncHist_q <= sync2_q;
            edge_q     <= sync2_q & ~syncHist_q;
        end
    end

    // An edge always wins over a timeout that falls in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rawPeriod_q <= '0;
            measDone_q  <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            measDone_q <= 1'b0;
            if (!en) begin
                state_q   <= IDLE;
                count_q   <= '0;
                locked_q  <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        count_q <= '0;
                        state_q <= ARM;
                    end
                    ARM: begin
                        if (edge_q) begin
                            state_q   <= MEAS;
                            count_q   <= '0;
                            timeout_q <= 1'b0;
                        end else if (count_q == TIMEOUT_LAST) begin
                            count_q   <= '0;
                            locked_q  <= 1'b0;
                            timeout_q <= 1'b1;
                        end else begin
                            count_q <= countInc;
                        end
                    end
                    MEAS: begin
                        if (edge_q) begin
                            rawPeriod_q <= countInc;
                            measDone_q  <= 1'b1;
                            count_q     <= '0;
                            locked_q    <= 1'b1;
                            timeout_q   <= 1'b0;
                        end else if (count_q == TIMEOUT_LAST) begin
                            state_q   <= ARM;
                            count_q   <= '0;
                            locked_q  <= 1'b0;
                            timeout_q <= 1'b1;
                        end else begin
                            count_q <= countInc;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end
                endcase
            end
        end
    end

`ifdef PERIOD_AVG_EN
    logic [W-1:0] avgHist_q [4];
    logic [W+1:0] avgAcc_q;
    logic [W+1:0] avgSum;
    logic [2:0]   fill_q;

    assign avgSum = avgAcc_q + {2'b00, rawPeriod_q} - {2'b00, avgHist_q[3]};

    // History is flushed whenever measurement is not running, so it restarts after timeout or disable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q <= '0;
            valid_q  <= 1'b0;
            avgAcc_q <= '0;
            fill_q   <= '0;
            for (int i = 0; i < 4; i++) avgHist_q[i] <= '0;
        end else begin
            valid_q <= 1'b0;
            if (state_q != MEAS) begin
                avgAcc_q <= '0;
                fill_q   <= '0;
                for (int i = 0; i < 4; i++) avgHist_q[i] <= '0;
            end else if (measDone_q) begin
                avgHist_q[0] <= rawPeriod_q;
                for (int i = 1; i < 4; i++) avgHist_q[i] <= avgHist_q[i-1];
                avgAcc_q <= avgSum;
                if (fill_q >= 3'd3) begin
                    period_q <= avgSum[W+1:2];
                    valid_q  <= 1'b1;
                    fill_q   <= 3'd4;
                end else begin
                    fill_q <= fill_q + 3'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= measDone_q;
            if (measDone_q) period_q <= rawPeriod_q;
        end
    end
`endif

    assign period       = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule
